pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 32 +++
 rtl/pipe_stage_reg_skid_buf.sv | 59 +++++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: payload/counter widths
// and the occupancy state encoding used by the skid-buffer controller.
package pipe_stage_reg_pkg;

  // Default payload width: wd, wreg, wdata, hi, lo, whilo, aluop, mem_addr,
  // reg2, cp0 fields and pc packed together.
  localparam int PAYLOAD_W = 160;

  // Width of the occupancy count (0..2 entries).
  localparam int LEVEL_W = 2;

  // Width of the saturating stall counter and its ceiling.
  localparam int STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // Occupancy of the stage: nothing held, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Number of entries held in a given occupancy state.
  function automatic logic [LEVEL_W-1:0] state_level(input stage_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// Two-entry payload storage for the skid variant of the stage register.
// The main register feeds the output; the skid register catches the one
// extra entry accepted while the downstream stage is not consuming.
// All sequencing decisions come from the controller in pipe_stage_reg.
module skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = PAYLOAD_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              main_load,
  input  logic              main_from_skid,
  input  logic              skid_load,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] main_data
);

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;

  // Next payloads: clearing wins, a skid-to-main move empties the skid slot.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (clear) begin
      main_d = BUBBLE_VAL;
      skid_d = BUBBLE_VAL;
    end else begin
      if (main_load) begin
        if (main_from_skid) begin
          main_d = skid_q;
          skid_d = BUBBLE_VAL;
        end else begin
          main_d = in_data;
        end
      end
      if (skid_load) begin
        skid_d = in_data;
      end
    end
  end

  // Payload registers, reset to the bubble value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign main_data = main_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. SKID=1 gives a two-entry skid buffer
// with a registered in_ready (no combinational path from out_ready); SKID=0
// gives a single register whose in_ready looks through to out_ready.
// A saturating counter records cycles in which upstream was stalled.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W     = PAYLOAD_W,
  parameter int                SKID       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [LEVEL_W-1:0] level,
  output logic [STALL_W-1:0] stall_cycles
);

  logic [STALL_W-1:0] stall_q, stall_d;

  if (SKID != 0) begin : g_skid

    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              in_xfer, out_xfer;
    logic              main_load, main_from_skid, skid_load, buf_clear;
    logic [DATA_W-1:0] main_data;

    // Occupancy controller: next state, storage steering and next in_ready.
    always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      in_xfer        = in_valid && in_ready_q;
      out_xfer       = (state_q != ST_EMPTY) && out_ready;
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            state_d   = ST_TWO;
            skid_load = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_xfer) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
      if (flush) begin
        state_d        = ST_EMPTY;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
      end
      buf_clear  = (state_d == ST_EMPTY);
      in_ready_d = (state_d != ST_TWO);
    end

    // State and registered in_ready; reset leaves the stage empty and open.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        in_ready_q <= in_ready_d;
      end
    end

    skid_buf #(
      .DATA_W     (DATA_W),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid_buf (
      .clk            (clk),
      .rst            (rst),
      .clear          (buf_clear),
      .main_load      (main_load),
      .main_from_skid (main_from_skid),
      .skid_load      (skid_load),
      .in_data        (in_data),
      .main_data      (main_data)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data;
    assign level     = state_level(state_q);

  end else begin : g_single

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ready_c;

    assign ready_c = !valid_q || out_ready;

    // Single register: refill on input, drop to bubble when drained or flushed.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
        data_d  = BUBBLE_VAL;
      end else if (in_valid && ready_c) begin
        valid_d = 1'b1;
        data_d  = in_data;
      end else if (valid_q && out_ready) begin
        valid_d = 1'b0;
        data_d  = BUBBLE_VAL;
      end
    end

    // Payload and valid flag, reset to an empty bubble.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q <= 1'b0;
        data_q  <= BUBBLE_VAL;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign in_ready  = ready_c;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign level     = {1'b0, valid_q};

  end

  // Stall counter next value: count refused offers, stick at the ceiling.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 instance at default width and a SKID=0
// instance (16-bit, non-zero bubble) share one set of upstream/downstream
// inputs. Each is tracked by a queue model of the stage occupancy.
module tb_pipe_stage_reg;

  localparam int          W1   = 160;
  localparam int          W0   = 16;
  localparam logic [15:0] BUB0 = 16'hDEAD;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [W1-1:0] in_data;
  logic          out_ready;

  logic          in_ready1, out_valid1;
  logic [W1-1:0] out_data1;
  logic [1:0]    level1;
  logic [15:0]   stall1;

  logic          in_ready0, out_valid0;
  logic [W0-1:0] out_data0;
  logic [1:0]    level0;
  logic [15:0]   stall0;

  int checks = 0;
  int errors = 0;

  logic [W1-1:0] q1[$];
  logic [W0-1:0] q0[$];
  int            m_stall1;
  int            m_stall0;

  typedef struct {
    logic          fl;
    logic          iv;
    logic [W1-1:0] d;
    logic          ordy;
    logic          ov;
    logic [W1-1:0] od;
    logic [1:0]    lv;
    logic          ir;
    logic [15:0]   st;
  } vec_t;

  vec_t tbl[18];

  pipe_stage_reg #(
    .DATA_W     (W1),
    .SKID       (1)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready1),
    .out_valid    (out_valid1),
    .out_data     (out_data1),
    .out_ready    (out_ready),
    .level        (level1),
    .stall_cycles (stall1)
  );

  pipe_stage_reg #(
    .DATA_W     (W0),
    .SKID       (0),
    .BUBBLE_VAL (BUB0)
  ) dut0 (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data[W0-1:0]),
    .in_ready     (in_ready0),
    .out_valid    (out_valid0),
    .out_data     (out_data0),
    .out_ready    (out_ready),
    .level        (level0),
    .stall_cycles (stall0)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic fl, input logic iv, input logic [W1-1:0] d,
                               input logic ordy, input logic ov, input logic [W1-1:0] od,
                               input logic [1:0] lv, input logic ir, input logic [15:0] st);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.lv = lv; v.ir = ir; v.st = st;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [W1-1:0] act, input logic [W1-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic iv, input logic [W1-1:0] d,
                               input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  // Compare both instances against the occupancy models (call at negedge).
  task automatic checkOutput();
    logic [W1-1:0] exp1;
    logic [W0-1:0] exp0;
    logic          ir0;
    exp1 = (q1.size() > 0) ? q1[0] : '0;
    exp0 = (q0.size() > 0) ? q0[0] : BUB0;
    ir0  = (q0.size() == 0) || out_ready;
    cmp("skid.out_valid", out_valid1, q1.size() > 0);
    cmp("skid.out_data", out_data1, exp1);
    cmp("skid.level", level1, q1.size());
    cmp("skid.in_ready", in_ready1, q1.size() < 2);
    cmp("skid.stall_cycles", stall1, m_stall1);
    cmp("single.out_valid", out_valid0, q0.size() > 0);
    cmp("single.out_data", out_data0, exp0);
    cmp("single.level", level0, q0.size());
    cmp("single.in_ready", in_ready0, ir0);
    cmp("single.stall_cycles", stall0, m_stall0);
  endtask

  // Take the rising edge and apply the transfer rules to the models.
  task automatic advance();
    logic ir1, ir0, ix1, ix0, ox1, ox0;
    ir1 = (q1.size() < 2);
    ir0 = (q0.size() == 0) || out_ready;
    ix1 = in_valid && ir1;
    ix0 = in_valid && ir0;
    ox1 = (q1.size() > 0) && out_ready;
    ox0 = (q0.size() > 0) && out_ready;
    @(posedge clk);
    if (in_valid && !ir1 && m_stall1 < 65535) m_stall1++;
    if (in_valid && !ir0 && m_stall0 < 65535) m_stall0++;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (ox1) void'(q1.pop_front());
      if (ix1) q1.push_back(in_data);
      if (ox0) void'(q0.pop_front());
      if (ix0) q0.push_back(in_data[W0-1:0]);
    end
    #1;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    advance();
  endtask

  // Asynchronous reset away from any clock edge, checked while still asserted.
  task automatic doReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    q1.delete();
    q0.delete();
    m_stall1 = 0;
    m_stall0 = 0;
    #2;
    cmp("rst.skid.out_valid", out_valid1, 1'b0);
    cmp("rst.skid.out_data", out_data1, '0);
    cmp("rst.skid.level", level1, 2'd0);
    cmp("rst.skid.in_ready", in_ready1, 1'b1);
    cmp("rst.skid.stall_cycles", stall1, 16'd0);
    cmp("rst.single.out_valid", out_valid0, 1'b0);
    cmp("rst.single.out_data", out_data0, BUB0);
    cmp("rst.single.level", level0, 2'd0);
    cmp("rst.single.in_ready", in_ready0, 1'b1);
    cmp("rst.single.stall_cycles", stall0, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    m_stall1 = 0;
    m_stall0 = 0;
    repeat (2) @(posedge clk);
    #1;
    doReset();

    // Backpressure, flush-over-input and flush-with-output vectors for SKID=1.
    tbl[0]  = mkv(0, 0, 160'h0, 0, 0, 160'h0, 2'd0, 1, 16'd0);
    tbl[1]  = mkv(0, 1, 160'hA, 0, 0, 160'h0, 2'd0, 1, 16'd0);
    tbl[2]  = mkv(0, 1, 160'hB, 0, 1, 160'hA, 2'd1, 1, 16'd0);
    tbl[3]  = mkv(0, 1, 160'hC, 0, 1, 160'hA, 2'd2, 0, 16'd0);
    tbl[4]  = mkv(0, 1, 160'hC, 0, 1, 160'hA, 2'd2, 0, 16'd1);
    tbl[5]  = mkv(0, 1, 160'hC, 1, 1, 160'hA, 2'd2, 0, 16'd2);
    tbl[6]  = mkv(0, 1, 160'hC, 0, 1, 160'hB, 2'd1, 1, 16'd3);
    tbl[7]  = mkv(0, 0, 160'h0, 1, 1, 160'hB, 2'd2, 0, 16'd3);
    tbl[8]  = mkv(0, 0, 160'h0, 1, 1, 160'hC, 2'd1, 1, 16'd3);
    tbl[9]  = mkv(0, 0, 160'h0, 0, 0, 160'h0, 2'd0, 1, 16'd3);
    tbl[10] = mkv(0, 1, 160'h1, 0, 0, 160'h0, 2'd0, 1, 16'd3);
    tbl[11] = mkv(0, 1, 160'h2, 0, 1, 160'h1, 2'd1, 1, 16'd3);
    tbl[12] = mkv(1, 1, 160'hD, 0, 1, 160'h1, 2'd2, 0, 16'd3);
    tbl[13] = mkv(0, 0, 160'h0, 1, 0, 160'h0, 2'd0, 1, 16'd4);
    tbl[14] = mkv(0, 0, 160'h0, 1, 0, 160'h0, 2'd0, 1, 16'd4);
    tbl[15] = mkv(0, 1, 160'hE, 0, 0, 160'h0, 2'd0, 1, 16'd4);
    tbl[16] = mkv(1, 0, 160'h0, 1, 1, 160'hE, 2'd1, 1, 16'd4);
    tbl[17] = mkv(0, 0, 160'h0, 0, 0, 160'h0, 2'd0, 1, 16'd4);

    $display("[TB] table vectors");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      checkOutput();
      cmp($sformatf("row%0d.out_valid", i), out_valid1, tbl[i].ov);
      cmp($sformatf("row%0d.out_data", i), out_data1, tbl[i].od);
      cmp($sformatf("row%0d.level", i), level1, tbl[i].lv);
      cmp($sformatf("row%0d.in_ready", i), in_ready1, tbl[i].ir);
      cmp($sformatf("row%0d.stall_cycles", i), stall1, tbl[i].st);
      advance();
    end

    // Reset while both entries are occupied.
    $display("[TB] reset mid-transfer");
    applyStimulus(1'b0, 1'b1, 160'h55, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 160'h66, 1'b0);
    stepCycle();
    doReset();

    // Streaming 1..8 with both sides always ready: one-cycle latency, in order.
    $display("[TB] streaming");
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b0, k <= 8, W1'(k), 1'b1);
      @(negedge clk);
      checkOutput();
      cmp($sformatf("stream%0d.in_ready", k), in_ready1, 1'b1);
      if (k >= 2) begin
        cmp($sformatf("stream%0d.out_valid", k), out_valid1, 1'b1);
        cmp($sformatf("stream%0d.out_data", k), out_data1, W1'(k - 1));
      end
      advance();
    end

    // out_ready toggling every cycle with a continuous upstream offer.
    $display("[TB] toggled out_ready");
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, W1'(16'h100 + k), k[0]);
      stepCycle();
    end

    // Randomised traffic including occasional flushes.
    $display("[TB] random traffic");
    for (int k = 0; k < 1500; k++) begin
      applyStimulus($urandom_range(15) == 0, $urandom_range(3) != 0,
                    {$urandom, $urandom, $urandom, $urandom, $urandom},
                    $urandom_range(2) != 0);
      stepCycle();
    end

    // Long stall to drive both counters into saturation.
    $display("[TB] stall saturation");
    for (int k = 0; k < 70000; k++) begin
      applyStimulus(1'b0, 1'b1, W1'(k), 1'b0);
      stepCycle();
    end
    @(negedge clk);
    cmp("sat.skid.stall_cycles", stall1, 16'hFFFF);
    cmp("sat.single.stall_cycles", stall0, 16'hFFFF);
    advance();
    for (int k = 0; k < 5; k++) stepCycle();
    @(negedge clk);
    cmp("sat_hold.skid.stall_cycles", stall1, 16'hFFFF);
    cmp("sat_hold.single.stall_cycles", stall0, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
